// File: rtl/crc8_pkg.sv
// Shared constants and the reference CRC-8 (poly 0x07) function for the 64-bit encoder.
// Data bit 0 is the MSB and is consumed first.
package crc8_pkg;

  localparam int DATA_W = 64;
  localparam int CRC_W  = 8;
  localparam int CODE_W = 72;

  localparam logic [CRC_W-1:0] CRC8_POLY = 8'h07;
  localparam logic [CRC_W-1:0] CRC8_INIT = 8'h00;

  // Loop is fully unrolled by synthesis into a flat XOR network.
  function automatic logic [CRC_W-1:0] crc8_calc(input logic [0:DATA_W-1] data);
    logic [CRC_W-1:0] crc;
    logic             fb;
    crc = CRC8_INIT;
    for (int i = 0; i < DATA_W; i++) begin
      fb  = crc[CRC_W-1] ^ data[i];
      crc = {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC8_POLY : '0);
    end
    return crc;
  endfunction

endpackage

// File: rtl/crc8_64_calc.sv
// Combinational CRC-8 over a 64-bit word; no state.
module crc8_64_calc
  import crc8_pkg::*;
(
  input  logic [0:DATA_W-1] i_data,
  output logic [CRC_W-1:0]  o_crc
);

  assign o_crc = crc8_calc(i_data);

endmodule

// File: rtl/crc8_64_encoder.sv
// Systematic CRC-8 encoder: registers {data, crc} in one cycle; o_valid marks fresh words.
// Output register holds its value while enable is low.
module crc8_64_encoder
  import crc8_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [0:DATA_W-1] i_data,
  output logic [0:CODE_W-1] o_code,
  output logic              o_valid
);

  logic [CRC_W-1:0]  crc;
  logic [0:CODE_W-1] code_d, code_q;
  logic              valid_d, valid_q;

  crc8_64_calc u_calc (
    .i_data (i_data),
    .o_crc  (crc)
  );

  always_comb begin
    code_d  = code_q;
    valid_d = 1'b0;
    if (enable) begin
      code_d  = {i_data, crc};
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign o_code  = code_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_crc8_64_encoder.sv
// Scoreboard bench for crc8_64_encoder; reference CRC is polynomial long division (data * x^8 mod 0x107).
module tb_crc8_64_encoder;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [0:63] i_data;
  logic [0:71] o_code;
  logic        o_valid;

  crc8_64_encoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .i_data  (i_data),
    .o_code  (o_code),
    .o_valid (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_rst;
    bit          has_ne;
    logic [71:0] code;
    logic        valid;
    logic [7:0]  ne;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  bit          chk_on = 1'b0;
  logic [71:0] last_code = '0;

  // Remainder of (d * x^8) divided by x^8+x^2+x+1, MSB of d treated as highest power.
  function automatic logic [7:0] model_crc(input logic [63:0] d);
    logic [71:0] r;
    logic [71:0] g;
    r = {d, 8'h00};
    for (int i = 71; i >= 8; i--) begin
      if (r[i]) begin
        g = 72'h107;
        r = r ^ (g << (i - 8));
      end
    end
    return r[7:0];
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      exp_t        e;
      logic [71:0] got;
      got = o_code;
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL no_expectation: got code=%h valid=%b, required a queued word", got, o_valid);
      end else begin
        e = q.pop_front();
        if (e.is_rst) begin
          total++;
          if (got !== 72'h0 || o_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_clear: got code=%h valid=%b, required 0/0", got, o_valid);
          end
        end else begin
          total++;
          if (o_valid !== e.valid) begin
            bad++;
            $display("FAIL valid: got %b, required %b", o_valid, e.valid);
          end
          total++;
          if (got !== e.code) begin
            bad++;
            $display("FAIL code: got %h, required %h", got, e.code);
          end
          if (e.has_ne) begin
            total++;
            if (got[7:0] === e.ne) begin
              bad++;
              $display("FAIL bit_order: got crc %h, which equals the bit-reversed result %h", got[7:0], e.ne);
            end
          end
        end
      end
    end
  end

  task automatic drive(input logic en, input logic [63:0] d, input logic [7:0] c,
                       input bit has_ne, input logic [7:0] ne);
    exp_t e;
    e.is_rst = 1'b0;
    e.has_ne = has_ne;
    e.ne     = ne;
    if (en) begin
      last_code = {d, c};
      e.valid   = 1'b1;
    end else begin
      e.valid   = 1'b0;
    end
    e.code = last_code;
    q.push_back(e);
    enable = en;
    i_data = d;
    @(negedge clk); #1;
  endtask

  task automatic drive_rand(input logic en);
    logic [63:0] d;
    d = {$urandom(), $urandom()};
    drive(en, d, model_crc(d), 1'b0, 8'h00);
  endtask

  task automatic push_rst();
    exp_t e;
    e.is_rst = 1'b1;
    e.has_ne = 1'b0;
    e.code   = '0;
    e.valid  = 1'b0;
    e.ne     = '0;
    q.push_back(e);
    last_code = '0;
  endtask

  initial begin
    logic [63:0] a, b;
    logic [7:0]  ca, cb;

    reset_n = 1'b0;
    enable  = 1'b1;
    i_data  = 64'hDEAD_BEEF_0123_4567;
    repeat (3) @(negedge clk);
    #1;
    chk_on = 1'b1;
    push_rst(); @(negedge clk); #1;
    push_rst(); @(negedge clk); #1;
    reset_n = 1'b1;

    drive_rand(1'b0);

    drive(1'b1, 64'h0000000000000001, 8'h07, 1'b0, 8'h00);
    drive(1'b1, 64'h0000000000000080, 8'h89, 1'b0, 8'h00);
    drive(1'b1, 64'h0000000000000100, 8'h15, 1'b0, 8'h00);
    drive(1'b1, 64'h0000000000000000, 8'h00, 1'b0, 8'h00);
    drive(1'b1, 64'h0000000000000081, 8'h8E, 1'b0, 8'h00);
    drive(1'b1, 64'h8000000000000000, model_crc(64'h8000000000000000), 1'b1,
          model_crc(64'h0000000000000001));

    for (int k = 0; k < 8; k++) begin
      a  = {$urandom(), $urandom()};
      b  = {$urandom(), $urandom()};
      ca = model_crc(a);
      cb = model_crc(b);
      drive(1'b1, a, ca, 1'b0, 8'h00);
      drive(1'b1, b, cb, 1'b0, 8'h00);
      drive(1'b1, a ^ b, ca ^ cb, 1'b0, 8'h00);
    end

    for (int k = 0; k < 40; k++) drive_rand(1'b1);

    for (int k = 0; k < 3; k++) drive_rand(1'b0);
    drive_rand(1'b1);

    for (int k = 0; k < 4; k++) drive_rand(1'b1);
    // Reset drops between edges; the monitor samples before any further rising edge.
    push_rst();
    enable = 1'b1;
    i_data = {$urandom(), $urandom()};
    @(posedge clk); #2;
    reset_n = 1'b0;
    @(negedge clk); #1;
    reset_n = 1'b1;

    drive_rand(1'b0);
    for (int k = 0; k < 20; k++) drive_rand(1'($urandom_range(0, 1)));
    drive_rand(1'b0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
